// File: rtl/cpu_pkg.sv
// Shared definitions for multicycle execution-unit controllers.
package cpu_pkg;

  // HI/LO-related op codes seen by the mul/div controller.
  typedef enum logic [1:0] {
    OpMult = 2'b00,
    OpDiv  = 2'b01,
    OpMthi = 2'b10,
    OpMtlo = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCommit,
    StErr
  } state_e;

  typedef enum logic {
    CauseTimeout,
    CauseDivZero
  } err_cause_e;

  localparam int unsigned DefaultTimeout = 48;

endpackage

// File: rtl/op_timer.sv
// Saturating cycle counter that flags the Limit-th enabled cycle after a clear.
module op_timer #(
  parameter int unsigned Limit = 48
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW  = $clog2(Limit + 1);
  localparam logic [CntW-1:0] LimitC = CntW'(Limit);
  localparam logic [CntW-1:0] LastC  = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at Limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LimitC)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires during the Limit-th enabled cycle so the caller leaves on that edge.
  assign expired_o = enable_i && (cnt_q >= LastC);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: launches an external multiplier or divider, waits for it,
// commits results or raises an exception; MTHI/MTLO write HI/LO directly.
module muldiv_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned OP_W    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            op_start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [31:0]     a_i,
  input  logic [31:0]     b_i,
  output logic            mult_start_o,
  output logic            div_start_o,
  output logic [31:0]     unit_a_o,
  output logic [31:0]     unit_b_o,
  input  logic            mult_done_i,
  input  logic            div_done_i,
  input  logic            div_zero_i,
  input  logic [31:0]     mult_hi_i,
  input  logic [31:0]     mult_lo_i,
  input  logic [31:0]     div_hi_i,
  input  logic [31:0]     div_lo_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            div_zero_exc_o,
  output logic            timeout_exc_o,
  output logic [31:0]     hi_o,
  output logic [31:0]     lo_o
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  err_cause_e cause_q, cause_d;
  logic [31:0] unit_a_q, unit_a_d;
  logic [31:0] unit_b_q, unit_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic timer_clear, timer_en, timer_expired;
  op_e  op_in;

  assign op_in = op_e'(op_i[1:0]);

  op_timer #(
    .Limit (TIMEOUT)
  ) u_op_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  // Next-state and output decode for the controller FSM.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cause_d        = cause_q;
    unit_a_d       = unit_a_q;
    unit_b_d       = unit_b_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    timer_clear    = 1'b0;
    timer_en       = 1'b0;
    mult_start_o   = 1'b0;
    div_start_o    = 1'b0;
    done_o         = 1'b0;
    div_zero_exc_o = 1'b0;
    timeout_exc_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // rst_ni gate keeps the combinational MTHI/MTLO done low while in reset.
        if (op_start_i && rst_ni) begin
          unique case (op_in)
            OpMult, OpDiv: begin
              op_d     = op_in;
              unit_a_d = a_i;
              unit_b_d = b_i;
              state_d  = StLaunch;
            end
            OpMthi: begin
              hi_d   = a_i;
              done_o = 1'b1;
            end
            OpMtlo: begin
              lo_d   = a_i;
              done_o = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StLaunch: begin
        mult_start_o = (op_q == OpMult);
        div_start_o  = (op_q == OpDiv);
        timer_clear  = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        timer_en = 1'b1;
        // Divide-by-zero beats a same-cycle div_done; a done beats a same-cycle expiry.
        if ((op_q == OpDiv) && div_zero_i) begin
          cause_d = CauseDivZero;
          state_d = StErr;
        end else if (((op_q == OpMult) && mult_done_i) || ((op_q == OpDiv) && div_done_i)) begin
          state_d = StCommit;
        end else if (timer_expired) begin
          cause_d = CauseTimeout;
          state_d = StErr;
        end
      end
      StCommit: begin
        done_o  = 1'b1;
        hi_d    = (op_q == OpDiv) ? div_hi_i : mult_hi_i;
        lo_d    = (op_q == OpDiv) ? div_lo_i : mult_lo_i;
        state_d = StIdle;
      end
      StErr: begin
        div_zero_exc_o = (cause_q == CauseDivZero);
        timeout_exc_o  = (cause_q == CauseTimeout);
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched operands and architectural HI/LO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      cause_q  <= CauseTimeout;
      unit_a_q <= '0;
      unit_b_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cause_q  <= cause_d;
      unit_a_q <= unit_a_d;
      unit_b_q <= unit_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign unit_a_o = unit_a_q;
  assign unit_b_o = unit_b_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the bench itself plays the multiplier/divider.
module tb_muldiv_ctrl;

  localparam int unsigned Tmo = 48;

  logic        clk, rst_n;
  logic        op_start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic        mult_done, div_done, div_zero;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        busy, done, div_zero_exc, timeout_exc;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int wait_cnt;
  logic seen;

  muldiv_ctrl #(
    .TIMEOUT (Tmo),
    .OP_W    (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .op_start_i     (op_start),
    .op_i           (op),
    .a_i            (a),
    .b_i            (b),
    .mult_start_o   (mult_start),
    .div_start_o    (div_start),
    .unit_a_o       (unit_a),
    .unit_b_o       (unit_b),
    .mult_done_i    (mult_done),
    .div_done_i     (div_done),
    .div_zero_i     (div_zero),
    .mult_hi_i      (mult_hi),
    .mult_lo_i      (mult_lo),
    .div_hi_i       (div_hi),
    .div_lo_i       (div_lo),
    .busy_o         (busy),
    .done_o         (done),
    .div_zero_exc_o (div_zero_exc),
    .timeout_exc_o  (timeout_exc),
    .hi_o           (hi),
    .lo_o           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    op_start = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
  endtask

  initial begin
    rst_n = 1'b0; op_start = 1'b0; op = 2'b00; a = '0; b = '0;
    mult_done = 1'b0; div_done = 1'b0; div_zero = 1'b0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_unit_a", unit_a, 32'h0);
    step();
    rst_n = 1'b1;

    // DIV 7 / 2 -> hi=1 lo=3
    step();
    issue(2'b01, 32'd7, 32'd2);
    step();
    op_start = 1'b0;
    chk1("div1_busy", busy, 1'b1);
    chk1("div1_div_start", div_start, 1'b1);
    chk1("div1_mult_start", mult_start, 1'b0);
    chk("div1_unit_a", unit_a, 32'd7);
    chk("div1_unit_b", unit_b, 32'd2);
    step();
    chk1("div1_start_one_cycle", div_start, 1'b0);
    div_done = 1'b1; div_hi = 32'd1; div_lo = 32'd3;
    step();
    div_done = 1'b0;
    chk1("div1_done", done, 1'b1);
    chk1("div1_busy_commit", busy, 1'b1);
    chk("div1_unit_a_hold", unit_a, 32'd7);
    step();
    chk1("div1_done_pulse", done, 1'b0);
    chk1("div1_idle", busy, 1'b0);
    chk("div1_hi", hi, 32'd1);
    chk("div1_lo", lo, 32'd3);

    // DIV -7 / 2 -> hi=-1 lo=-3, issued right after the previous op returned to IDLE
    issue(2'b01, 32'hFFFF_FFF9, 32'd2);
    step();
    op_start = 1'b0;
    chk1("div2_div_start", div_start, 1'b1);
    step();
    div_done = 1'b1; div_hi = 32'hFFFF_FFFF; div_lo = 32'hFFFF_FFFD;
    step();
    div_done = 1'b0;
    chk1("div2_done", done, 1'b1);
    step();
    chk("div2_hi", hi, 32'hFFFF_FFFF);
    chk("div2_lo", lo, 32'hFFFF_FFFD);

    // MTHI / MTLO 0x55
    issue(2'b10, 32'h55, 32'h0);
    #1;
    chk1("mthi_done", done, 1'b1);
    chk1("mthi_no_start", mult_start | div_start, 1'b0);
    step();
    issue(2'b11, 32'h55, 32'h0);
    #1;
    chk1("mtlo_done", done, 1'b1);
    chk("mthi_hi", hi, 32'h55);
    chk1("mthi_stay_idle", busy, 1'b0);
    step();
    op_start = 1'b0;
    #1;
    chk1("mtlo_done_pulse", done, 1'b0);
    chk("mtlo_lo", lo, 32'h55);

    // DIV by zero with a simultaneous div_done -> exception wins
    step();
    issue(2'b01, 32'd9, 32'd0);
    step();
    op_start = 1'b0;
    step();
    div_zero = 1'b1; div_done = 1'b1; div_hi = 32'hAAAA; div_lo = 32'hBBBB;
    step();
    div_zero = 1'b0; div_done = 1'b0;
    chk1("dz_exc", div_zero_exc, 1'b1);
    chk1("dz_no_tmo", timeout_exc, 1'b0);
    chk1("dz_no_done", done, 1'b0);
    step();
    chk1("dz_exc_pulse", div_zero_exc, 1'b0);
    chk1("dz_idle", busy, 1'b0);
    chk("dz_hi", hi, 32'h55);
    chk("dz_lo", lo, 32'h55);

    // MULT 0x10000 * 0x10000, unit done on the 32nd WAIT cycle; an MTHI mid-wait is ignored
    issue(2'b00, 32'h0001_0000, 32'h0001_0000);
    step();
    op_start = 1'b0;
    chk1("mul_mult_start", mult_start, 1'b1);
    chk1("mul_div_start", div_start, 1'b0);
    for (int i = 1; i < 32; i++) begin
      step();
      op_start = (i == 5);
      op       = 2'b10;
      a        = 32'hDEAD;
      div_done = (i == 10);  // wrong unit, must be ignored
    end
    chk1("mul_still_busy", busy, 1'b1);
    step();
    op_start = 1'b0; div_done = 1'b0;
    mult_done = 1'b1; mult_hi = 32'd1; mult_lo = 32'd0;
    step();
    mult_done = 1'b0;
    chk1("mul_done", done, 1'b1);
    step();
    chk("mul_hi", hi, 32'd1);
    chk("mul_lo", lo, 32'd0);
    chk("mul_unit_a", unit_a, 32'h0001_0000);

    // MULT with no unit response -> timeout after Tmo WAIT cycles
    issue(2'b00, 32'd3, 32'd4);
    step();
    op_start = 1'b0;
    chk1("tmo_mult_start", mult_start, 1'b1);
    wait_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (timeout_exc) seen = 1'b1;
      else wait_cnt++;
    end
    chk1("tmo_seen", seen, 1'b1);
    chk("tmo_cycles", wait_cnt, Tmo);
    chk1("tmo_no_dz", div_zero_exc, 1'b0);
    chk1("tmo_no_done", done, 1'b0);
    step();
    chk1("tmo_idle", busy, 1'b0);
    chk("tmo_hi", hi, 32'd1);
    chk("tmo_lo", lo, 32'd0);

    // Reset during DIV WAIT, then a stray div_done after release
    issue(2'b01, 32'd100, 32'd5);
    step();
    op_start = 1'b0;
    step();
    chk1("rw_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rw_busy", busy, 1'b0);
    chk("rw_hi", hi, 32'h0);
    chk("rw_lo", lo, 32'h0);
    chk("rw_unit_a", unit_a, 32'h0);
    chk("rw_unit_b", unit_b, 32'h0);
    chk1("rw_starts", mult_start | div_start, 1'b0);
    chk1("rw_exc", div_zero_exc | timeout_exc, 1'b0);
    step();
    rst_n = 1'b1;
    div_done = 1'b1; div_hi = 32'h1234; div_lo = 32'h5678;
    step();
    div_done = 1'b0;
    chk1("rw_stray_done", done, 1'b0);
    chk1("rw_stray_busy", busy, 1'b0);
    step();
    chk("rw_stray_lo", lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 48, max cycles waited for a unit done before abort.
REQ-002 SHALL have parameter OP_W, default 2, width of op code.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 op_start  input  1  one-cycle request from control unit.
REQ-006 op  input  OP_W  00=MULT, 01=DIV, 10=MTHI, 11=MTLO.
REQ-007 a, b  input  32 each  operands, sampled on accepted op_start.
REQ-008 mult_start, div_start  output  1 each  one-cycle start pulse to multiplier / divider.
REQ-009 unit_a, unit_b  output  32 each  latched operands driven to both units.
REQ-010 mult_done, div_done  input  1 each  one-cycle completion pulses from units.
REQ-011 div_zero  input  1  divider divide-by-zero flag.
REQ-012 mult_hi, mult_lo, div_hi, div_lo  input  32 each  unit results.
REQ-013 busy  output  1  high from accept until done/error cycle inclusive.
REQ-014 done  output  1  one-cycle pulse, HI/LO updated.
REQ-015 div_zero_exc, timeout_exc  output  1 each  one-cycle exception pulses.
REQ-016 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT, COMMIT, ERR.
REQ-018 op_start SHALL be accepted only in IDLE; requests while busy SHALL be ignored with no side effect.
REQ-019 IDLE + op_start, op MULT/DIV -> latch a,b,op; go LAUNCH; busy=1 next cycle.
REQ-020 IDLE + op_start, op MTHI/MTLO -> write a into hi/lo next edge, pulse done same cycle, stay IDLE; no unit started.
REQ-021 LAUNCH SHALL pulse exactly one of mult_start/div_start for one cycle, clear timeout counter, go WAIT.
REQ-022 WAIT SHALL count cycles; selected unit's done -> COMMIT; other unit's done ignored.
REQ-023 DIV in WAIT: div_zero=1 at any cycle -> ERR, overriding a same-cycle div_done.
REQ-024 WAIT counter reaching TIMEOUT with no done -> ERR with timeout cause.
REQ-025 COMMIT SHALL load hi/lo from selected unit's hi/lo, pulse done, return to IDLE (total MULT/DIV latency = unit latency + 3 cycles from op_start to done).
REQ-026 ERR SHALL pulse div_zero_exc or timeout_exc (exactly one), leave hi/lo unchanged, return to IDLE.
REQ-027 done and exception pulses SHALL be mutually exclusive and one cycle wide.
REQ-028 unit_a/unit_b SHALL hold latched values stable from LAUNCH through COMMIT/ERR.
REQ-029 New op_start SHALL be accepted in the cycle after COMMIT/ERR (back-to-back allowed).
REQ-030 Timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits, saturating, never wrapping.

Reset
REQ-031 reset=0 SHALL force IDLE, hi=lo=0, unit_a=unit_b=0, busy=done=exceptions=starts=0, counter=0, asynchronously.
REQ-032 reset mid-operation SHALL abandon the op; late unit done after release SHALL be ignored in IDLE.
REQ-033 Deassertion SHALL take effect at the next posedge; first accept possible that edge.

Structure
REQ-034 Op codes, FSM state enum and default TIMEOUT SHALL live in shared package cpu_pkg.
REQ-035 Timeout counter SHALL be sub-module op_timer (clear, enable, expired) reusable by other multicycle controllers.
REQ-036 Multiplier and divider SHALL remain external; the block instantiates neither.

Verification
REQ-037 DIV a=7, b=2 -> one div_start, done pulse, hi=1, lo=3.
REQ-038 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 hi=lo=0x55 preset by MTHI/MTLO, then DIV b=0 -> div_zero_exc pulse, no done, hi=lo=0x55.
REQ-040 MULT 0x00010000*0x00010000 with stub done after 32 cycles -> hi=1, lo=0; op_start during WAIT ignored.
REQ-041 Stub never returns done -> timeout_exc exactly TIMEOUT cycles after LAUNCH exit, FSM IDLE.
REQ-042 reset=0 during WAIT of DIV -> all outputs 0 same cycle; post-release stray div_done produces no done.
